// File: rtl/maxpool_pkg.sv
// Shared helpers for the row-streaming max-pooling stage: output geometry,
// a signed max over sign-extended words, and a parameter legality check.
package maxpool_pkg;

  // Widest word the signed max helper handles; narrower words are sign-extended.
  localparam int MAXW = 64;

  function automatic int OW(input int w, input int k);
    return w / k;
  endfunction

  function automatic int OH(input int h, input int k);
    return h / k;
  endfunction

  function automatic logic signed [MAXW-1:0] smax(input logic signed [MAXW-1:0] a,
                                                   input logic signed [MAXW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic bit params_ok(input int k, input int w, input int h);
    return (k >= 2) && (k <= 4) && (w >= k) && (h >= k);
  endfunction

endpackage

// File: rtl/maxpool_hmax.sv
// Horizontal K-wide signed max over one feature-map row, per channel.
// Columns beyond the last full window are ignored.
module maxpool_hmax
  import maxpool_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int W         = 48,
  parameter int K         = 2
) (
  input  logic [W*D*DATA_BITS-1:0]        row,
  output logic [(W/K)*D*DATA_BITS-1:0]    hmax
);

  localparam int NOW = OW(W, K);

  for (genvar j = 0; j < NOW; j++) begin : g_col
    for (genvar d = 0; d < D; d++) begin : g_ch
      logic signed [MAXW-1:0] m;
      // Reduce the K words of window j, channel d
      always_comb begin
        m = MAXW'($signed(row[((j*K)*D+d)*DATA_BITS +: DATA_BITS]));
        for (int i = 1; i < K; i++)
          m = smax(m, MAXW'($signed(row[((j*K+i)*D+d)*DATA_BITS +: DATA_BITS])));
        hmax[(j*D+d)*DATA_BITS +: DATA_BITS] = DATA_BITS'(m);
      end
    end
  end

  if (NOW*K < W) begin : g_trunc
    logic unused_cols;
    assign unused_cols = ^row[W*D*DATA_BITS-1:NOW*K*D*DATA_BITS];
  end

endmodule

// File: rtl/max_pooling_stream.sv
// KxK / stride-K max pooling over a stream of full feature-map rows.
// One pooled row leaves per K accepted rows; trailing rows that do not fill
// a window are consumed silently. Optional fused ReLU: MAXPOOL_RELU_EN.
module max_pooling_stream
  import maxpool_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int D         = 1,
  parameter int H         = 48,
  parameter int W         = 48,
  parameter int K         = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [W*D*DATA_BITS-1:0]          in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [(W/K)*D*DATA_BITS-1:0]      out_data,
  output logic                              out_last
);

  localparam int NOW = OW(W, K);
  localparam int NOH = OH(H, K);
  localparam int OWB = NOW*D*DATA_BITS;
  localparam int FRW = $clog2(H+1);
  localparam int RW  = (K > 2) ? $clog2(K) : 1;

  if (!params_ok(K, W, H)) begin : g_bad_params
    $error("max_pooling_stream: need 2 <= K <= 4, W >= K, H >= K");
  end

  logic [OWB-1:0] hmax, vmax, res, acc;
  logic [FRW-1:0] fr;
  logic [RW-1:0]  r;
  logic           acc_fire, in_frame, win_done;

  assign in_ready = !out_valid | out_ready;
  assign acc_fire = in_valid & in_ready;
  assign in_frame = fr < FRW'(NOH*K);
  assign win_done = (r == RW'(K-1));

  maxpool_hmax #(.DATA_BITS(DATA_BITS), .D(D), .W(W), .K(K)) u_hmax (
    .row  (in_data),
    .hmax (hmax)
  );

  for (genvar w = 0; w < NOW*D; w++) begin : g_word
    // Vertical max against the running accumulator, then optional clamp
    always_comb begin
      vmax[w*DATA_BITS +: DATA_BITS] = DATA_BITS'(smax(MAXW'($signed(acc[w*DATA_BITS +: DATA_BITS])),
                                                       MAXW'($signed(hmax[w*DATA_BITS +: DATA_BITS]))));
`ifdef MAXPOOL_RELU_EN
      res[w*DATA_BITS +: DATA_BITS] = vmax[w*DATA_BITS + DATA_BITS-1] ? '0 : vmax[w*DATA_BITS +: DATA_BITS];
`else
      res[w*DATA_BITS +: DATA_BITS] = vmax[w*DATA_BITS +: DATA_BITS];
`endif
    end
  end

  // Frame/window counters, accumulator and output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      r         <= '0;
      fr        <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (acc_fire) begin
        if (in_frame) begin
          acc <= (r == '0) ? hmax : vmax;
          if (win_done) begin
            out_data  <= res;
            out_valid <= 1'b1;
            out_last  <= (fr == FRW'(NOH*K-1));
          end
        end
        if (fr == FRW'(H-1)) begin
          fr <= '0;
          r  <= '0;
        end else begin
          fr <= fr + 1'b1;
          r  <= win_done ? '0 : r + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pooling_stream.sv
// Directed bench: DATA_BITS=32, D=2, W=5, H=5, K=2 (truncated column and row).
module tb_max_pooling_stream;

  localparam int DB  = 32;
  localparam int D   = 2;
  localparam int H   = 5;
  localparam int W   = 5;
  localparam int K   = 2;
  localparam int IW  = W*D*DB;
  localparam int OWD = (W/K)*D*DB;

  logic           clk = 1'b0;
  logic           reset, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [IW-1:0]  in_data;
  logic [OWD-1:0] out_data;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  max_pooling_stream #(.DATA_BITS(DB), .D(D), .H(H), .W(W), .K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [OWD-1:0] obs, input logic [OWD-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [IW-1:0] pack(input int c0[5], input int c1[5]);
    logic [IW-1:0] v;
    v = '0;
    for (int x = 0; x < W; x++) begin
      v[(x*D+0)*DB +: DB] = c0[x];
      v[(x*D+1)*DB +: DB] = c1[x];
    end
    return v;
  endfunction

  function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Words in output order: (j0,d0), (j0,d1), (j1,d0), (j1,d1)
  function automatic logic [OWD-1:0] exp4(input int a, input int b, input int c, input int e);
    logic [OWD-1:0] v;
    v[0*DB +: DB] = relu(a);
    v[1*DB +: DB] = relu(b);
    v[2*DB +: DB] = relu(c);
    v[3*DB +: DB] = relu(e);
    return v;
  endfunction

  // Reference 2x2 pool over two rows, ignoring column 4
  function automatic logic [OWD-1:0] ref_pool(input logic [IW-1:0] a, input logic [IW-1:0] b);
    logic [OWD-1:0] v;
    int m, t;
    for (int j = 0; j < 2; j++)
      for (int d = 0; d < D; d++) begin
        m = a[(j*2*D+d)*DB +: DB];
        for (int x = j*2; x < j*2+2; x++) begin
          t = a[(x*D+d)*DB +: DB]; if (t > m) m = t;
          t = b[(x*D+d)*DB +: DB]; if (t > m) m = t;
        end
        v[(j*D+d)*DB +: DB] = relu(m);
      end
    return v;
  endfunction

  function automatic logic [IW-1:0] rnd_row(input bit put_min);
    logic [IW-1:0] v;
    for (int i = 0; i < W*D; i++) v[i*DB +: DB] = $urandom;
    if (put_min) v[1*DB +: DB] = 32'h8000_0000;
    return v;
  endfunction

  task automatic send(input logic [IW-1:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("send_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [OWD-1:0] held, e;
    logic [IW-1:0]  ra, rb, r2;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_in_ready",  in_ready,  1);
    reset = 1'b1;
    tick();

    // Frame 1, window 0, with downstream stalled
    out_ready = 1'b0;
    send(pack('{1, 5, -3, 2, 100}, '{-1, -5, 3, -2, 100}));
    chk("no_out_after_row0", out_valid, 0);
    send(pack('{4, 0, -7, -1, 100}, '{-4, 0, 7, 1, 100}));
    chk("w0_valid", out_valid, 1);
    chk("w0_data",  out_data, exp4(5, 0, 2, 7));
    chk("w0_last",  out_last, 0);
    chk("w0_stall_in_ready", in_ready, 0);

    // Backpressure: row 2 waits, output held
    held = out_data;
    r2 = pack('{-8, -9, 3, 3, 100}, '{32'h8000_0000, 32'h8000_0000, -5, -6, 100});
    in_data = r2; in_valid = 1'b1;
    tick(); tick(); tick();
    chk("bp_hold_data",  out_data, held);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_in_ready",   in_ready, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_drained", out_valid, 0);

    // Frame 1, window 1 (last)
    send(pack('{-2, -6, 0, 7, 100}, '{32'h8000_0000, -7, -9, -5, 100}));
    chk("w1_valid", out_valid, 1);
    chk("w1_data",  out_data, exp4(-2, -7, 7, -5));
    chk("w1_last",  out_last, 1);

    // Truncated row 4: consumed, no output
    send(pack('{50, 50, 50, 50, 50}, '{50, 50, 50, 50, 50}));
    chk("trunc_no_out", out_valid, 0);

    // Frame 2 first window after wrap
    send(pack('{10, 20, 30, 40, 100}, '{-1, -1, -1, -1, 100}));
    out_ready = 1'b0;
    send(pack('{0, 0, 0, 0, 100}, '{-2, -3, -4, -5, 100}));
    chk("f2_valid", out_valid, 1);
    chk("f2_data",  out_data, exp4(20, -1, 40, -1));
    chk("f2_last",  out_last, 0);
    out_ready = 1'b1;

    // Mid-frame reset after one row of a window
    send(pack('{90, 90, 90, 90, 90}, '{90, 90, 90, 90, 90}));
    reset = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data",  out_data, 0);
    tick();
    reset = 1'b1;
    tick();
    send(pack('{1, 1, 1, 1, 1}, '{1, 1, 1, 1, 1}));
    send(pack('{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}));
    chk("midrst_out_valid", out_valid, 1);
    chk("midrst_out_data",  out_data, exp4(1, 1, 1, 1));
    chk("midrst_out_last",  out_last, 0);

    // Random signed data including the most negative value (rows 2,3 of frame)
    ra = rnd_row(1'b1); rb = rnd_row(1'b0);
    send(ra); send(rb);
    chk("rnd0_data", out_data, ref_pool(ra, rb));
    chk("rnd0_last", out_last, 1);
    send(rnd_row(1'b0));
    chk("rnd_trunc_no_out", out_valid, 0);
    for (int p = 0; p < 2; p++) begin
      ra = rnd_row(p == 0); rb = rnd_row(p == 1);
      send(ra); send(rb);
      e = ref_pool(ra, rb);
      chk("rnd_valid", out_valid, 1);
      chk("rnd_data",  out_data, e);
      chk("rnd_last",  out_last, (p == 1) ? 1 : 0);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule
